// File: rtl/compositor_pkg.sv
// Shared types and default constants for the lane compositor.
package compositor_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned DEF_NUM_LANES     = 4;
  localparam int unsigned DEF_OBJS_PER_LANE = 4;
  localparam int unsigned DEF_COORD_W       = 11;
  localparam int unsigned DEF_OBJ_W         = 80;
  localparam int unsigned DEF_OBJ_H         = 40;
  localparam int unsigned DEF_WRAP_X        = 680;
  localparam int unsigned DEF_FLASH_FRAMES  = 30;

  localparam rgb_t FLASH_RGB = '{r: 8'hFF, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/lane_compositor_if.sv
// Pixel/object bus of the lane compositor. The master drives the scene and pixel
// stream; the slave (compositor) returns the composited pixel.
interface lane_compositor_if
  import compositor_pkg::*;
#(
  parameter int unsigned NUM_LANES     = DEF_NUM_LANES,
  parameter int unsigned OBJS_PER_LANE = DEF_OBJS_PER_LANE,
  parameter int unsigned COORD_W       = DEF_COORD_W
);
  logic                                                 frame_start;
  logic                                                 pix_valid;
  logic [COORD_W-1:0]                                   DrawX;
  logic [COORD_W-1:0]                                   DrawY;
  logic [NUM_LANES-1:0][OBJS_PER_LANE-1:0][COORD_W-1:0] obj_x;
  logic [NUM_LANES-1:0][OBJS_PER_LANE-1:0][COORD_W-1:0] obj_y;
  logic [NUM_LANES-1:0][2:0]                            lane_count;
  rgb_t [NUM_LANES-1:0]                                 lane_rgb;
  rgb_t                                                 bg_rgb;
  logic [NUM_LANES-1:0]                                 collision;
  logic                                                 out_valid;
  logic [7:0]                                           Red;
  logic [7:0]                                           Green;
  logic [7:0]                                           Blue;
  logic [NUM_LANES-1:0]                                 hit_lane;

  modport master (
    output frame_start, pix_valid, DrawX, DrawY, obj_x, obj_y, lane_count, lane_rgb, bg_rgb,
           collision,
    input  out_valid, Red, Green, Blue, hit_lane
  );

  modport slave (
    input  frame_start, pix_valid, DrawX, DrawY, obj_x, obj_y, lane_count, lane_rgb, bg_rgb,
           collision,
    output out_valid, Red, Green, Blue, hit_lane
  );
endinterface

// File: rtl/lane_hit.sv
// Combinational hit test of one lane: OR of all active slot rectangle hits.
// Objects at or beyond WRAP_X have wrapped around the coordinate space, so only
// their (modulo) right edge is tested against DrawX.
module lane_hit
  import compositor_pkg::*;
#(
  parameter int unsigned OBJS_PER_LANE = DEF_OBJS_PER_LANE,
  parameter int unsigned COORD_W       = DEF_COORD_W,
  parameter int unsigned OBJ_W         = DEF_OBJ_W,
  parameter int unsigned OBJ_H         = DEF_OBJ_H,
  parameter int unsigned WRAP_X        = DEF_WRAP_X
) (
  input  logic [OBJS_PER_LANE-1:0][COORD_W-1:0] i_obj_x,
  input  logic [OBJS_PER_LANE-1:0][COORD_W-1:0] i_obj_y,
  input  logic [2:0]                            i_count,
  input  logic [COORD_W-1:0]                    i_draw_x,
  input  logic [COORD_W-1:0]                    i_draw_y,
  output logic                                  o_hit
);
  localparam int unsigned XW = COORD_W + 1;

  logic [OBJS_PER_LANE-1:0] w_slot_hit;

  for (genvar k = 0; k < OBJS_PER_LANE; k++) begin : g_slot
    logic [XW-1:0] w_x_end;
    logic [XW-1:0] w_y_end;
    logic          w_wrap;
    logic          w_x_in;
    logic          w_y_in;
    logic          w_active;

    // Extents computed one bit wider so the right/bottom edge never overflows.
    assign w_x_end  = {1'b0, i_obj_x[k]} + XW'(OBJ_W);
    assign w_y_end  = {1'b0, i_obj_y[k]} + XW'(OBJ_H);
    assign w_wrap   = ({1'b0, i_obj_x[k]} >= XW'(WRAP_X));
    assign w_x_in   = w_wrap ? (i_draw_x <= w_x_end[COORD_W-1:0])
                             : ((i_draw_x >= i_obj_x[k]) && ({1'b0, i_draw_x} <= w_x_end));
    assign w_y_in   = (i_draw_y >= i_obj_y[k]) && ({1'b0, i_draw_y} <= w_y_end);
    assign w_active = (32'(i_count) > k);
    assign w_slot_hit[k] = w_active && w_x_in && w_y_in;
  end

  assign o_hit = |w_slot_hit;

endmodule

// File: rtl/lane_compositor.sv
// Two-stage sprite-lane compositor: stage 1 registers per-lane hits, stage 2
// registers the priority-selected colour (lowest lane wins, else background).
// Optional collision flash (red background) is built only when the macro
// LANE_COMPOSITOR_FLASH_EN is defined.
module lane_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned NUM_LANES     = DEF_NUM_LANES,
  parameter int unsigned OBJS_PER_LANE = DEF_OBJS_PER_LANE,
  parameter int unsigned COORD_W       = DEF_COORD_W,
  parameter int unsigned OBJ_W         = DEF_OBJ_W,
  parameter int unsigned OBJ_H         = DEF_OBJ_H,
  parameter int unsigned WRAP_X        = DEF_WRAP_X,
  parameter int unsigned FLASH_FRAMES  = DEF_FLASH_FRAMES
) (
  input logic              Clk,
  input logic              Reset,
  lane_compositor_if.slave io_bus
);
  localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);

  logic [NUM_LANES-1:0] w_lane_hit;
  logic [NUM_LANES-1:0] r_hit1;
  logic                 r_valid1;
  rgb_t                 r_bg1;
  logic                 w_flash_active;
  rgb_t                 w_sel_rgb;
  logic [NUM_LANES-1:0] w_sel_onehot;
  logic                 r_valid2;
  rgb_t                 r_rgb2;
  logic [NUM_LANES-1:0] r_hit2;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_hit #(
      .OBJS_PER_LANE (OBJS_PER_LANE),
      .COORD_W       (COORD_W),
      .OBJ_W         (OBJ_W),
      .OBJ_H         (OBJ_H),
      .WRAP_X        (WRAP_X)
    ) u_lane_hit (
      .i_obj_x  (io_bus.obj_x[l]),
      .i_obj_y  (io_bus.obj_y[l]),
      .i_count  (io_bus.lane_count[l]),
      .i_draw_x (io_bus.DrawX),
      .i_draw_y (io_bus.DrawY),
      .o_hit    (w_lane_hit[l])
    );
  end

  // Stage 1: capture lane hits with the pixel qualifier and background colour.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hit1   <= '0;
      r_valid1 <= 1'b0;
      r_bg1    <= '0;
    end else begin
      r_hit1   <= w_lane_hit;
      r_valid1 <= io_bus.pix_valid;
      r_bg1    <= io_bus.bg_rgb;
    end
  end

  // Priority select: scan from the top so the lowest hitting lane wins.
  always_comb begin
    w_sel_onehot = '0;
    w_sel_rgb    = w_flash_active ? FLASH_RGB : r_bg1;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (r_hit1[l]) begin
        w_sel_onehot    = '0;
        w_sel_onehot[l] = 1'b1;
        w_sel_rgb       = io_bus.lane_rgb[l];
      end
    end
  end

  // Stage 2: register the composited pixel and its qualifier.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid2 <= 1'b0;
      r_rgb2   <= '0;
      r_hit2   <= '0;
    end else begin
      r_valid2 <= r_valid1;
      r_rgb2   <= w_sel_rgb;
      r_hit2   <= w_sel_onehot;
    end
  end

`ifdef LANE_COMPOSITOR_FLASH_EN
  logic [CNT_W-1:0] r_flash_cnt;

  // Flash counter: collision reloads (and beats frame_start); frames count down to 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_flash_cnt <= '0;
    end else if (|io_bus.collision) begin
      r_flash_cnt <= CNT_W'(FLASH_FRAMES);
    end else if (io_bus.frame_start && (r_flash_cnt != '0)) begin
      r_flash_cnt <= r_flash_cnt - 1'b1;
    end
  end

  assign w_flash_active = (r_flash_cnt != '0);
`else
  logic w_unused_flash;
  assign w_unused_flash = ^{io_bus.collision, io_bus.frame_start, CNT_W};
  assign w_flash_active = 1'b0;
`endif

  assign io_bus.out_valid = r_valid2;
  assign io_bus.Red       = r_rgb2.r;
  assign io_bus.Green     = r_rgb2.g;
  assign io_bus.Blue      = r_rgb2.b;
  assign io_bus.hit_lane  = r_hit2;

endmodule

// File: tb/tb_lane_compositor.sv
// Directed self-checking bench for lane_compositor (4 lanes x 4 slots, 11-bit
// coordinates). Flash checks are compiled in only with LANE_COMPOSITOR_FLASH_EN.
module tb_lane_compositor;
  import compositor_pkg::*;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  lane_compositor_if #(
    .NUM_LANES     (4),
    .OBJS_PER_LANE (4),
    .COORD_W       (11)
  ) bus ();

  lane_compositor #(
    .FLASH_FRAMES (3)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .io_bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_objs();
    for (int l = 0; l < 4; l++) begin
      bus.lane_count[l] = 3'd0;
      for (int k = 0; k < 4; k++) begin
        bus.obj_x[l][k] = 11'd0;
        bus.obj_y[l][k] = 11'd0;
      end
    end
  endtask

  // One isolated pixel; result appears two clock edges after capture.
  task automatic pixel(input string tag, input int x, input int y, input logic [23:0] bg,
                       input logic [23:0] exp_rgb, input logic [3:0] exp_hit);
    @(negedge Clk);
    bus.pix_valid = 1'b1;
    bus.DrawX     = 11'(x);
    bus.DrawY     = 11'(y);
    bus.bg_rgb    = bg;
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    bus.DrawX     = 11'd0;
    bus.DrawY     = 11'd0;
    @(posedge Clk);
    #1;
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_rgb"}, 32'({bus.Red, bus.Green, bus.Blue}), 32'(exp_rgb));
    check_eq({tag, "_hit"}, 32'(bus.hit_lane), 32'(exp_hit));
  endtask

  task automatic pulse(input logic col, input logic fs);
    @(negedge Clk);
    bus.collision   = col ? 4'b0001 : 4'b0000;
    bus.frame_start = fs;
    @(negedge Clk);
    bus.collision   = 4'b0000;
    bus.frame_start = 1'b0;
  endtask

  logic [7:0] vpat;
  logic [7:0] hpat;

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.bg_rgb      = '0;
    bus.collision   = '0;
    bus.lane_rgb[0] = 24'h112233;
    bus.lane_rgb[1] = 24'h445566;
    bus.lane_rgb[2] = 24'h778899;
    bus.lane_rgb[3] = 24'hAABBCC;
    clear_objs();

    // Reset state
    #23;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'd0);
    check_eq("rst_hit", 32'(bus.hit_lane), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Basic hit and inclusive edges
    bus.lane_count[0] = 3'd1;
    bus.obj_x[0][0]   = 11'd100;
    bus.obj_y[0][0]   = 11'd280;
    pixel("basic_tl", 100, 280, 24'h0A0B0C, 24'h112233, 4'b0001);
    pixel("basic_br", 180, 320, 24'h0A0B0C, 24'h112233, 4'b0001);
    pixel("basic_xout", 181, 280, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);
    pixel("basic_yout", 100, 321, 24'h0D0E0F, 24'h0D0E0F, 4'b0000);

    // Wrapped object: right edge (2040+80) mod 2048 = 72
    bus.obj_x[0][0] = 11'd2040;
    bus.obj_y[0][0] = 11'd100;
    pixel("wrap_in", 30, 120, 24'h0A0B0C, 24'h112233, 4'b0001);
    pixel("wrap_edge", 72, 120, 24'h0A0B0C, 24'h112233, 4'b0001);
    pixel("wrap_out", 73, 120, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);

    // Overlap of lanes 1 and 2: lane 1 wins
    clear_objs();
    bus.lane_count[1] = 3'd1;
    bus.obj_x[1][0]   = 11'd200;
    bus.obj_y[1][0]   = 11'd200;
    bus.lane_count[2] = 3'd2;
    bus.obj_x[2][1]   = 11'd210;
    bus.obj_y[2][1]   = 11'd210;
    pixel("overlap", 220, 220, 24'h0A0B0C, 24'h445566, 4'b0010);
    pixel("lane2_only", 285, 245, 24'h0A0B0C, 24'h778899, 4'b0100);

    // Inactive slot must not hit
    clear_objs();
    bus.lane_count[0] = 3'd2;
    bus.obj_x[0][0]   = 11'd500;
    bus.obj_y[0][0]   = 11'd10;
    bus.obj_x[0][1]   = 11'd500;
    bus.obj_y[0][1]   = 11'd10;
    bus.obj_x[0][3]   = 11'd300;
    bus.obj_y[0][3]   = 11'd300;
    pixel("slot3_off", 310, 310, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);
    bus.lane_count[0] = 3'd4;
    pixel("slot3_on", 310, 310, 24'h0A0B0C, 24'h112233, 4'b0001);

    // Streaming: qualifier and data advance every cycle, latency 2
    clear_objs();
    bus.lane_count[0] = 3'd1;
    bus.obj_x[0][0]   = 11'd100;
    bus.obj_y[0][0]   = 11'd280;
    vpat = 8'b1110_1101;
    hpat = 8'b0100_1011;
    for (int c = 0; c < 9; c++) begin
      @(negedge Clk);
      bus.pix_valid = (c < 8) ? vpat[c] : 1'b0;
      bus.DrawX     = ((c < 8) && hpat[c]) ? 11'd100 : 11'd500;
      bus.DrawY     = 11'd280;
      @(posedge Clk);
      #1;
      if (c >= 1) begin
        check_eq($sformatf("stream_v%0d", c - 1), 32'(bus.out_valid), 32'(vpat[c-1]));
        check_eq($sformatf("stream_h%0d", c - 1), 32'(bus.hit_lane), 32'(hpat[c-1]));
      end
    end

    // Reset mid-burst
    @(negedge Clk);
    bus.pix_valid = 1'b1;
    bus.DrawX     = 11'd100;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check_eq("burst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'd0);
    check_eq("arst_hit", 32'(bus.hit_lane), 32'd0);
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_eq("post_rst_idle", 32'(bus.out_valid), 32'd0);
    bus.pix_valid = 1'b1;
    @(negedge Clk);
    check_eq("post_rst_lat1", 32'(bus.out_valid), 32'd0);
    bus.pix_valid = 1'b0;
    @(negedge Clk);
    check_eq("post_rst_lat2", 32'(bus.out_valid), 32'd1);
    check_eq("post_rst_hit", 32'(bus.hit_lane), 32'd1);

    // Collision flash
`ifdef LANE_COMPOSITOR_FLASH_EN
    pulse(1'b1, 1'b0);
    pixel("flash_f0", 600, 10, 24'h0A0B0C, 24'hFF0000, 4'b0000);
    pixel("flash_lane", 100, 280, 24'h0A0B0C, 24'h112233, 4'b0001);
    pulse(1'b0, 1'b1);
    pixel("flash_f1", 600, 10, 24'h0A0B0C, 24'hFF0000, 4'b0000);
    pulse(1'b0, 1'b1);
    pixel("flash_f2", 600, 10, 24'h0A0B0C, 24'hFF0000, 4'b0000);
    pulse(1'b0, 1'b1);
    pixel("flash_end", 600, 10, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);
    pulse(1'b0, 1'b1);
    pixel("flash_sat", 600, 10, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);
    pulse(1'b1, 1'b1);
    pixel("coinc_f0", 600, 10, 24'h0A0B0C, 24'hFF0000, 4'b0000);
    pulse(1'b0, 1'b1);
    pixel("coinc_f1", 600, 10, 24'h0A0B0C, 24'hFF0000, 4'b0000);
    pulse(1'b0, 1'b1);
    pixel("coinc_f2", 600, 10, 24'h0A0B0C, 24'hFF0000, 4'b0000);
    pulse(1'b0, 1'b1);
    pixel("coinc_end", 600, 10, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);
`else
    pulse(1'b1, 1'b0);
    pixel("noflash_col", 600, 10, 24'h0A0B0C, 24'h0A0B0C, 4'b0000);
    pulse(1'b1, 1'b1);
    pixel("noflash_coinc", 600, 10, 24'h123456, 24'h123456, 4'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
